// File: rtl/timer_pkg.sv
// Shared definitions for the digital timer: FSM state encoding and datapath defaults.
// Also imported by the digital timer top level.
package timer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } timer_state_e;

  localparam int unsigned MAX_COUNT_DEFAULT   = 99;
  localparam int unsigned ALARM_TICKS_DEFAULT = 8;

  localparam int unsigned COUNT_W = 8;

endpackage : timer_pkg

// File: rtl/alarm_stretch.sv
// Holds the terminal-count alarm high for ALARM_TICKS tick strobes after DONE entry.
// A down-counter is loaded on entry, and the alarm drops on its terminal count.
module alarm_stretch
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic clear_i,
  input  logic start_i,
  input  logic active_i,
  input  logic tick_i,
  output logic alarm_o
);

  localparam logic [7:0] LOAD = 8'(ALARM_TICKS);

  logic [7:0] left_q;
  logic       alarm_q;

  always_ff @(posedge clk_i) begin
    if (reset_i || clear_i) begin
      left_q  <= 8'd0;
      alarm_q <= 1'b0;
    end else if (start_i) begin
      left_q  <= LOAD;
      alarm_q <= 1'b1;
    end else if (active_i && tick_i && (left_q != 8'd0)) begin
      left_q <= left_q - 8'd1;
      if (left_q == 8'd1) begin
        alarm_q <= 1'b0;
      end
    end
  end

  assign alarm_o = alarm_q;

endmodule : alarm_stretch

// File: rtl/timer_ctrl.sv
// Run/pause/lap/clear controller for the digital timer datapath counter.
//   state | meaning
//   IDLE  | stopped at zero, waiting for start_stop
//   RUN   | counter advances on tick
//   PAUSE | counter held, display may still be frozen
//   DONE  | terminal count reached, alarm stretch running
module timer_ctrl
  import timer_pkg::*;
#(
  parameter int unsigned MAX_COUNT   = MAX_COUNT_DEFAULT,
  parameter int unsigned ALARM_TICKS = ALARM_TICKS_DEFAULT
) (
  input  logic       clk_50MHz,
  input  logic       reset,
  input  logic       tick,
  input  logic       start_stop,
  input  logic       lap,
  input  logic       clear,
  input  logic [7:0] count,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       disp_hold,
  output logic [7:0] lap_val,
  output logic       done,
  output logic       alarm,
  output logic [1:0] state
);

  localparam logic [7:0] TERM    = 8'(MAX_COUNT);
  localparam logic [7:0] TERM_M1 = 8'(MAX_COUNT - 1);

  timer_state_e state_q, state_d;
  logic         hold_q, hold_d;
  logic [7:0]   lap_q, lap_d;
  logic         cnt_clr_q;
  logic         enter_done;
  logic         alarm_w;

  // Zero-latency grant: the datapath sees cnt_en in the same cycle as tick.
  assign cnt_en = (state_q == ST_RUN) && tick && (count < TERM);

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    lap_d      = lap_q;
    enter_done = 1'b0;
    if (clear) begin
      state_d = ST_IDLE;
      hold_d  = 1'b0;
      lap_d   = 8'd0;
    end else if (start_stop) begin
      unique case (state_q)
        ST_IDLE:  state_d = ST_RUN;
        ST_RUN:   state_d = ST_PAUSE;
        ST_PAUSE: state_d = ST_RUN;
        ST_DONE:  state_d = ST_DONE;
        default:  state_d = ST_IDLE;
      endcase
    end else begin
      // count >= TERM covers a datapath that got ahead of us (e.g. resumed past terminal).
      if ((state_q == ST_RUN) &&
          ((count >= TERM) || (cnt_en && (count == TERM_M1)))) begin
        state_d    = ST_DONE;
        enter_done = 1'b1;
      end
      if (lap) begin
        if (state_q == ST_RUN) begin
          if (hold_q) begin
            hold_d = 1'b0;
          end else begin
            hold_d = 1'b1;
            lap_d  = count;
          end
        end else if ((state_q == ST_PAUSE) && hold_q) begin
          hold_d = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk_50MHz) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      hold_q    <= 1'b0;
      lap_q     <= 8'd0;
      cnt_clr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hold_q    <= hold_d;
      lap_q     <= lap_d;
      cnt_clr_q <= clear;
    end
  end

  alarm_stretch #(
    .ALARM_TICKS(ALARM_TICKS)
  ) u_alarm_stretch (
    .clk_i   (clk_50MHz),
    .reset_i (reset),
    .clear_i (clear),
    .start_i (enter_done),
    .active_i(state_q == ST_DONE),
    .tick_i  (tick),
    .alarm_o (alarm_w)
  );

  assign cnt_clr   = cnt_clr_q;
  assign disp_hold = hold_q;
  assign lap_val   = lap_q;
  assign done      = (state_q == ST_DONE);
  assign alarm     = alarm_w;
  assign state     = state_q;

endmodule : timer_ctrl

// File: tb/tb_timer_ctrl.sv
// Bench for timer_ctrl: directed scenarios plus randomized pulses against a behavioural model.
// The bench also plays the datapath counter driven by cnt_en / cnt_clr.
module tb_timer_ctrl;

  localparam int MAXC  = 99;
  localparam int ALARM = 8;

  logic       clk_50MHz = 1'b0;
  logic       reset = 1'b0;
  logic       tick = 1'b0;
  logic       start_stop = 1'b0;
  logic       lap = 1'b0;
  logic       clear = 1'b0;
  logic [7:0] dp_count = 8'd0;
  logic       cnt_en, cnt_clr, disp_hold, done, alarm;
  logic [7:0] lap_val;
  logic [1:0] state;

  int n_checks = 0;
  int n_pass   = 0;

  // behavioural model: state as 0..3, alarm as remaining ticks
  int m_state, m_count, m_lap, m_alarm_left;
  bit m_hold, m_clr;
  bit exp_en, obs_en;

  timer_ctrl #(.MAX_COUNT(MAXC), .ALARM_TICKS(ALARM)) dut (
    .clk_50MHz (clk_50MHz),
    .reset     (reset),
    .tick      (tick),
    .start_stop(start_stop),
    .lap       (lap),
    .clear     (clear),
    .count     (dp_count),
    .cnt_en    (cnt_en),
    .cnt_clr   (cnt_clr),
    .disp_hold (disp_hold),
    .lap_val   (lap_val),
    .done      (done),
    .alarm     (alarm),
    .state     (state)
  );

  always #10 clk_50MHz = ~clk_50MHz;

  function automatic logic [13:0] exp_vec();
    return {2'(m_state), m_clr, m_hold, 8'(m_lap), (m_state == 3), (m_alarm_left > 0)};
  endfunction

  function automatic logic [13:0] obs_vec();
    return {state, cnt_clr, disp_hold, lap_val, done, alarm};
  endfunction

  task automatic model_reset();
    m_state = 0; m_count = 0; m_lap = 0; m_alarm_left = 0;
    m_hold = 0; m_clr = 0;
  endtask

  task automatic model_step(input bit t, input bit ss, input bit lp, input bit cl);
    int old_cnt, old_state;
    bit en;
    old_cnt   = m_count;
    old_state = m_state;
    en = (old_state == 1) && t && (old_cnt < MAXC);
    exp_en = en;
    if (m_clr) m_count = 0;
    else if (en) m_count = m_count + 1;
    m_clr = cl;
    if (old_state == 3 && t && m_alarm_left > 0) m_alarm_left = m_alarm_left - 1;
    if (cl) begin
      m_state = 0; m_hold = 0; m_lap = 0; m_alarm_left = 0;
    end else if (ss) begin
      if (old_state == 0) m_state = 1;
      else if (old_state == 1) m_state = 2;
      else if (old_state == 2) m_state = 1;
    end else begin
      if (old_state == 1 && (old_cnt >= MAXC || (en && old_cnt == MAXC - 1))) begin
        m_state = 3;
        m_alarm_left = ALARM;
      end
      if (lp) begin
        if (old_state == 1) begin
          if (m_hold) m_hold = 0;
          else begin m_hold = 1; m_lap = old_cnt; end
        end else if (old_state == 2 && m_hold) begin
          m_hold = 0;
        end
      end
    end
  endtask

  // One clock: drive pulses, sample cnt_en before the edge, then advance datapath and model.
  task automatic cycle(input bit t, input bit ss, input bit lp, input bit cl);
    bit en_pre, clr_pre;
    tick = t; start_stop = ss; lap = lp; clear = cl;
    #1;
    en_pre  = cnt_en;
    clr_pre = cnt_clr;
    obs_en  = en_pre;
    model_step(t, ss, lp, cl);
    @(posedge clk_50MHz);
    #1;
    if (clr_pre) dp_count = 8'd0;
    else if (en_pre) dp_count = dp_count + 8'd1;
    tick = 0; start_stop = 0; lap = 0; clear = 0;
  endtask

  task automatic do_reset(input bit t, input bit ss, input bit lp, input bit cl);
    reset = 1; tick = t; start_stop = ss; lap = lp; clear = cl;
    @(posedge clk_50MHz);
    #1;
    reset = 0; tick = 0; start_stop = 0; lap = 0; clear = 0;
    dp_count = 8'd0;
    model_reset();
  endtask

  task automatic preload(input int v);
    dp_count = 8'(v);
    m_count  = v;
  endtask

  task automatic test_reset();
    do_reset(1, 1, 1, 1);
    n_checks++;
    if (obs_vec() !== 14'd0) $display("FAIL reset_outputs: got %h expected %h", obs_vec(), 14'd0);
    else n_pass++;
    tick = 1;
    #1;
    n_checks++;
    if (cnt_en !== 1'b0) $display("FAIL reset_cnt_en: got %b expected 0", cnt_en);
    else n_pass++;
    tick = 0;
    cycle(0, 0, 0, 0);
    n_checks++;
    if (cnt_clr !== 1'b0 || state !== 2'd0) $display("FAIL reset_residual: cnt_clr %b state %0d expected 0/0", cnt_clr, state);
    else n_pass++;
  endtask

  task automatic test_basic_run();
    int grants;
    do_reset(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    grants = 0;
    for (int i = 0; i < 5; i++) begin
      cycle(1, 0, 0, 0);
      if (obs_en) grants++;
      cycle(0, 0, 0, 0);
      if (obs_en) grants += 100;
    end
    n_checks++;
    if (grants !== 5) $display("FAIL basic_grants: got %0d expected 5", grants);
    else n_pass++;
    n_checks++;
    if (dp_count !== 8'd5 || state !== 2'd1) $display("FAIL basic_final: count %0d state %0d expected 5/1", dp_count, state);
    else n_pass++;
  endtask

  task automatic test_terminal();
    do_reset(0, 0, 0, 0);
    preload(98);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++;
    if (obs_en !== 1'b1) $display("FAIL term_last_grant: got %b expected 1", obs_en);
    else n_pass++;
    n_checks++;
    if ({state, done, alarm} !== {2'd3, 1'b1, 1'b1}) $display("FAIL term_done: state %0d done %b alarm %b expected 3/1/1", state, done, alarm);
    else n_pass++;
    for (int i = 1; i <= ALARM; i++) begin
      cycle(1, 0, 0, 0);
      n_checks++;
      if (obs_en !== 1'b0) $display("FAIL term_no_grant: tick %0d got %b expected 0", i, obs_en);
      else n_pass++;
      n_checks++;
      if (alarm !== (i < ALARM) || done !== 1'b1) $display("FAIL term_alarm: tick %0d alarm %b done %b expected %b/1", i, alarm, done, (i < ALARM));
      else n_pass++;
      cycle(0, 0, 0, 0);
    end
    n_checks++;
    if (dp_count !== 8'd99) $display("FAIL term_count: got %0d expected 99", dp_count);
    else n_pass++;
  endtask

  task automatic test_lap();
    do_reset(0, 0, 0, 0);
    preload(37);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    n_checks++;
    if (disp_hold !== 1'b1 || lap_val !== 8'd37) $display("FAIL lap_capture: hold %b lap_val %0d expected 1/37", disp_hold, lap_val);
    else n_pass++;
    for (int i = 0; i < 3; i++) cycle(1, 0, 0, 0);
    n_checks++;
    if (dp_count !== 8'd40 || lap_val !== 8'd37) $display("FAIL lap_frozen: count %0d lap_val %0d expected 40/37", dp_count, lap_val);
    else n_pass++;
    cycle(0, 0, 1, 0);
    n_checks++;
    if (disp_hold !== 1'b0 || lap_val !== 8'd37) $display("FAIL lap_release: hold %b lap_val %0d expected 0/37", disp_hold, lap_val);
    else n_pass++;
  endtask

  task automatic test_priority();
    do_reset(0, 0, 0, 0);
    cycle(0, 1, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 1, 1, 1);
    n_checks++;
    if ({state, cnt_clr, disp_hold, lap_val} !== {2'd0, 1'b1, 1'b0, 8'd0})
      $display("FAIL prio_clear: state %0d cnt_clr %b hold %b lap_val %0d expected 0/1/0/0", state, cnt_clr, disp_hold, lap_val);
    else n_pass++;
    cycle(1, 0, 0, 0);
    n_checks++;
    if (cnt_clr !== 1'b0 || dp_count !== 8'd0 || obs_en !== 1'b0)
      $display("FAIL prio_one_shot: cnt_clr %b count %0d en %b expected 0/0/0", cnt_clr, dp_count, obs_en);
    else n_pass++;
  endtask

  task automatic test_pause();
    do_reset(0, 0, 0, 0);
    preload(10);
    cycle(0, 1, 0, 0);
    cycle(1, 1, 0, 0);
    n_checks++;
    if (obs_en !== 1'b1 || state !== 2'd2 || dp_count !== 8'd11)
      $display("FAIL pause_enter: en %b state %0d count %0d expected 1/2/11", obs_en, state, dp_count);
    else n_pass++;
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0);
    n_checks++;
    if (dp_count !== 8'd11) $display("FAIL pause_hold: count %0d expected 11", dp_count);
    else n_pass++;
    cycle(0, 1, 0, 0);
    n_checks++;
    if (state !== 2'd1) $display("FAIL pause_resume: state %0d expected 1", state);
    else n_pass++;
  endtask

  task automatic test_reset_mid_alarm();
    do_reset(0, 0, 0, 0);
    preload(98);
    cycle(0, 1, 0, 0);
    cycle(0, 0, 1, 0);
    cycle(1, 0, 0, 0);
    cycle(1, 0, 0, 0);
    n_checks++;
    if (alarm !== 1'b1 || state !== 2'd3) $display("FAIL midalarm_pre: alarm %b state %0d expected 1/3", alarm, state);
    else n_pass++;
    do_reset(1, 1, 1, 1);
    n_checks++;
    if (obs_vec() !== 14'd0) $display("FAIL midalarm_reset: got %h expected 0", obs_vec());
    else n_pass++;
    cycle(1, 0, 0, 0);
    n_checks++;
    if (cnt_clr !== 1'b0 || state !== 2'd0 || obs_en !== 1'b0) $display("FAIL midalarm_idle: cnt_clr %b state %0d en %b expected 0/0/0", cnt_clr, state, obs_en);
    else n_pass++;
    cycle(0, 1, 0, 0);
    n_checks++;
    if (state !== 2'd1) $display("FAIL midalarm_restart: state %0d expected 1", state);
    else n_pass++;
  endtask

  task automatic test_random();
    bit t, ss, lp, cl;
    do_reset(0, 0, 0, 0);
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset($urandom_range(0, 1), $urandom_range(0, 1), 0, $urandom_range(0, 1));
        n_checks++;
        if (obs_vec() !== exp_vec()) $display("FAIL rand_reset: cycle %0d got %h expected %h", i, obs_vec(), exp_vec());
        else n_pass++;
      end
      if (m_state == 0 && !m_clr && $urandom_range(0, 19) == 0) preload($urandom_range(85, 98));
      t  = ($urandom_range(0, 1) == 1);
      ss = ($urandom_range(0, 29) == 0);
      lp = ($urandom_range(0, 11) == 0);
      cl = ($urandom_range(0, 199) == 0);
      cycle(t, ss, lp, cl);
      n_checks++;
      if (obs_en !== exp_en) $display("FAIL rand_cnt_en: cycle %0d got %b expected %b", i, obs_en, exp_en);
      else n_pass++;
      n_checks++;
      if (obs_vec() !== exp_vec()) $display("FAIL rand_outputs: cycle %0d got %h expected %h", i, obs_vec(), exp_vec());
      else n_pass++;
      n_checks++;
      if (dp_count !== 8'(m_count)) $display("FAIL rand_count: cycle %0d got %0d expected %0d", i, dp_count, m_count);
      else n_pass++;
    end
  endtask

  initial begin
    model_reset();
    #5;
    test_reset();
    test_basic_run();
    test_terminal();
    test_lap();
    test_priority();
    test_pause();
    test_reset_mid_alarm();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule : tb_timer_ctrl

// File: doc/timer_ctrl.md
TIMER_CTRL -- requirements
Module: timer_ctrl

Interface
REQ-001 SHALL have parameter MAX_COUNT, default 99, the terminal count value of the timer datapath (1..255).
REQ-002 SHALL have parameter ALARM_TICKS, default 8, the number of tick strobes for which alarm stays high after terminal count (1..255).
REQ-003 SHALL have port clk_50MHz  in  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port tick  in  1  one-cycle count-rate strobe from the clock divider.
REQ-006 SHALL have port start_stop  in  1  one-cycle pulse; run/pause request.
REQ-007 SHALL have port lap  in  1  one-cycle pulse; freeze/release the display.
REQ-008 SHALL have port clear  in  1  one-cycle pulse; return to zero.
REQ-009 SHALL have port count  in  8  current binary value from the datapath counter.
REQ-010 SHALL have port cnt_en  out  1  datapath counter increments on this edge.
REQ-011 SHALL have port cnt_clr  out  1  datapath counter synchronous clear.
REQ-012 SHALL have port disp_hold  out  1  display shows lap_val instead of count.
REQ-013 SHALL have port lap_val  out  8  captured count for the frozen display.
REQ-014 SHALL have port done  out  1  high while in DONE state.
REQ-015 SHALL have port alarm  out  1  terminal-count alarm.
REQ-016 SHALL have port state  out  2  encoded FSM state: IDLE=0, RUN=1, PAUSE=2, DONE=3.

Function
REQ-017 SHALL implement the FSM with states IDLE, RUN, PAUSE and DONE; only the next state is registered.
REQ-018 SHALL resolve simultaneous pulses in the same cycle with priority clear > start_stop > lap; lower-priority pulses in that cycle are ignored.
REQ-019 SHALL, on clear in any state, go to IDLE next cycle, drive cnt_clr=1 for exactly that next cycle, and zero disp_hold, lap_val and alarm.
REQ-020 SHALL perform these start_stop transitions: IDLE->RUN, RUN->PAUSE, PAUSE->RUN; start_stop in DONE is ignored.
REQ-021 SHALL drive cnt_en combinationally as (state==RUN) & tick & (count < MAX_COUNT), giving zero latency from tick.
REQ-022 SHALL go RUN->DONE on the edge where cnt_en=1 and count==MAX_COUNT-1; it SHALL also go to DONE if in RUN with count >= MAX_COUNT (defensive), with cnt_en=0.
REQ-023 SHALL hold the counter in PAUSE and DONE: cnt_en=0, tick ignored.
REQ-024 SHALL handle lap in RUN with disp_hold=0 by capturing lap_val<=count and setting disp_hold=1 on the next edge.
REQ-025 SHALL release disp_hold on lap in RUN or PAUSE with disp_hold=1, leaving lap_val unchanged.
REQ-026 SHALL ignore lap in IDLE and DONE, and in PAUSE when disp_hold=0.
REQ-027 SHALL set alarm=1 on the edge DONE is entered, then count ticks while in DONE and drop alarm on the ALARM_TICKS-th tick; done stays 1 until clear.
REQ-028 SHALL have cnt_clr registered and never asserted except per REQ-019.
REQ-029 SHALL, if tick and start_stop coincide in RUN, pause on that edge and still grant that tick (cnt_en=1).

Reset
REQ-030 SHALL, with reset=1 at an edge, set state=IDLE, cnt_clr=0, disp_hold=0, lap_val=0, alarm=0, the alarm tick counter to 0, and hence done=0 and cnt_en=0.
REQ-031 SHALL give reset priority over all pulses, including mid-RUN and mid-alarm, with no residual pulses after release.

Structure
REQ-032 SHALL define the state encodings, default MAX_COUNT and default ALARM_TICKS in shared package timer_pkg, used also by digital timer top-level code.
REQ-033 SHALL place the alarm duration counter (set on DONE entry, decrement on tick, clear on reset/clear) in sub-module alarm_stretch; everything else stays in timer_ctrl.

Verification
REQ-034 SHALL verify basic run: reset, start_stop, 5 ticks with a counter model -> cnt_en high on exactly those 5 ticks, count=5, state=RUN.
REQ-035 SHALL verify terminal count: MAX_COUNT=99, RUN at count=98, one tick -> cnt_en=1, next cycle state=DONE, done=1, alarm=1; further ticks give no cnt_en; alarm drops on the 8th tick in DONE.
REQ-036 SHALL verify lap: RUN at count=37, lap -> lap_val=37, disp_hold=1; 3 ticks -> count=40, lap_val still 37; lap -> disp_hold=0.
REQ-037 SHALL verify priority: clear+start_stop+lap in the same cycle in RUN -> next state=IDLE, cnt_clr one cycle, disp_hold=0, no pause/lap effect.
REQ-038 SHALL verify pause: start_stop coinciding with tick at count=10 -> count=11, state=PAUSE; 4 ticks -> count stays 11; start_stop -> RUN.
REQ-039 SHALL verify reset mid-alarm: in DONE with alarm=1, assert reset one cycle -> all outputs at reset values next cycle, start_stop then enters RUN.
